// File: rtl/calc_cmd_driver.sv
// ---------------------------------------------------------------------------
// calc_cmd_driver
//
// Host-side initiator for the calculator chip command pins. Commands
// (opcode + operand) are queued in a small FIFO and replayed one at a time
// with fixed pin timing: setup, a one-cycle strobe, release, then a capture
// wait. The chip's result byte and flags are then presented on a response
// port.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A source never withdraws valid or changes its payload until the
// transfer. A sink may raise or drop ready freely.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command in; cmd_ready = FIFO not full
//   cmd_op[3:0], cmd_data    opcode and operand (operand unused for unary ops)
//   rsp_valid/rsp_ready      response out; rsp_* held until accepted
//   rsp_op, rsp_result,      completed opcode, sampled result/flags,
//   rsp_flags, rsp_err       err = reserved opcode (never sent to the chip)
//   busy                     FSM not idle or FIFO not empty
//   calc_data, calc_op,      chip operand, opcode and strobe pins
//   calc_strobe
//   calc_result, calc_flags  chip result and flag pins
//   dbg_state_o              current FSM state (IDLE = 0)
// ---------------------------------------------------------------------------
module calc_cmd_driver #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int CAPTURE_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_op,
  output logic [7:0] rsp_result,
  output logic [2:0] rsp_flags,
  output logic       rsp_err,
  output logic       busy,
  output logic [7:0] calc_data,
  output logic [3:0] calc_op,
  output logic       calc_strobe,
  input  logic [7:0] calc_result,
  input  logic [2:0] calc_flags,
  output logic [2:0] dbg_state_o
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (SETUP_CYCLES > CAPTURE_DELAY) ? SETUP_CYCLES : CAPTURE_DELAY;
  // Down-counter runs from N-1 to 0, so it only needs to hold CMAX-1.
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_RELEASE = 3'd3,
    S_WAIT    = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  // -------------------------------------------------------------------------
  // Command FIFO. Pointers carry one extra wrap bit so full and empty can be
  // told apart without a separate occupancy counter.
  // -------------------------------------------------------------------------
  logic [3:0]  fifo_op_q   [FIFO_DEPTH];
  logic [7:0]  fifo_data_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic [3:0]  head_op;
  logic [7:0]  head_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign head_op    = fifo_op_q[rd_ptr_q[AW-1:0]];
  assign head_data  = fifo_data_q[rd_ptr_q[AW-1:0]];

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[wr_ptr_q[AW-1:0]]   <= cmd_op;
      fifo_data_q[wr_ptr_q[AW-1:0]] <= cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Opcode classes: 0xB/0xC are reserved and never reach the pins; 5..0xA
  // are unary and leave the operand pins at their previous value.
  // -------------------------------------------------------------------------
  logic head_reserved, head_unary;
  assign head_reserved = (head_op == 4'hB) || (head_op == 4'hC);
  assign head_unary    = (head_op >= 4'h5) && (head_op <= 4'hA);

  // -------------------------------------------------------------------------
  // Sequencing FSM
  // -------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  calc_op_q, calc_op_d;
  logic [7:0]  calc_data_q, calc_data_d;
  logic        calc_strobe_q, calc_strobe_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [3:0]  rsp_op_q, rsp_op_d;
  logic [7:0]  rsp_result_q, rsp_result_d;
  logic [2:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_err_q, rsp_err_d;
  logic        launch;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    calc_op_d    = calc_op_q;
    calc_data_d  = calc_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    launch       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) launch = 1'b1;
      end
      S_SETUP: begin
        if (cnt_q == '0) state_d = S_STROBE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_STROBE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_WAIT;
        cnt_d   = CW'(CAPTURE_DELAY - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_op_d     = calc_op_q;
          rsp_result_d = calc_result;
          rsp_flags_d  = calc_flags;
          rsp_err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Chain straight into the next command to save the IDLE cycle.
          if (!fifo_empty) launch = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared pop path for IDLE and RESP exit.
    if (launch) begin
      if (head_reserved) begin
        // Pins untouched; the error response is ready on the next cycle.
        state_d      = S_RESP;
        rsp_valid_d  = 1'b1;
        rsp_op_d     = head_op;
        rsp_result_d = 8'h00;
        rsp_flags_d  = 3'b000;
        rsp_err_d    = 1'b1;
      end else begin
        state_d   = S_SETUP;
        cnt_d     = CW'(SETUP_CYCLES - 1);
        calc_op_d = head_op;
        if (!head_unary) calc_data_d = head_data;
      end
    end

    // Strobe is registered, so it is high exactly while the FSM sits in STROBE.
    calc_strobe_d = (state_d == S_STROBE);
  end

  assign pop = launch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      calc_op_q     <= '0;
      calc_data_q   <= '0;
      calc_strobe_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_op_q      <= '0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      calc_op_q     <= calc_op_d;
      calc_data_q   <= calc_data_d;
      calc_strobe_q <= calc_strobe_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_op_q      <= rsp_op_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign calc_op     = calc_op_q;
  assign calc_data   = calc_data_q;
  assign calc_strobe = calc_strobe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_calc_cmd_driver.sv
module tb_calc_cmd_driver;

  localparam int FIFO_DEPTH    = 4;
  localparam int SETUP_CYCLES  = 1;
  localparam int CAPTURE_DELAY = 1;

  logic       clk;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_op;
  logic [7:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       rsp_err;
  logic       busy;
  logic [7:0] calc_data;
  logic [3:0] calc_op;
  logic       calc_strobe;
  logic [7:0] calc_result;
  logic [2:0] calc_flags;
  logic [2:0] dbg_state_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int push_cyc = 0;

  // Scoreboard: expected response {op, result, flags, err} and expected pins {op, data}.
  logic [15:0] exp_q[$];
  logic [11:0] pin_q[$];
  int strobe_cycs[$];
  int rsp_rise[$];

  // Reference model state: chip accumulator and the operand last driven to the pins.
  logic [7:0] m_acc  = '0;
  logic [7:0] m_data = '0;

  bit   rand_ready  = 1'b0;
  logic force_ready = 1'b1;
  logic rnd_ready   = 1'b1;
  assign rsp_ready = rand_ready ? rnd_ready : force_ready;

  calc_cmd_driver #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .SETUP_CYCLES(SETUP_CYCLES),
    .CAPTURE_DELAY(CAPTURE_DELAY)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy),
    .calc_data(calc_data), .calc_op(calc_op), .calc_strobe(calc_strobe),
    .calc_result(calc_result), .calc_flags(calc_flags), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_ready <= ($urandom_range(0, 3) != 0);
  end

  // ---------------- calculator chip ----------------
  function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, d};
    case (op)
      4'h0: return a + d;
      4'h1: return a - d;
      4'h2: return a & d;
      4'h3: return a | d;
      4'h4: return a ^ d;
      4'h5: return a + 8'd1;
      4'h6: return a - 8'd1;
      4'h7: return ~a;
      4'h8: return {a[6:0], 1'b0};
      4'h9: return {1'b0, a[7:1]};
      4'hA: return 8'h00;
      4'hD: return d;
      4'hE: return p[7:0];
      4'hF: return d - a;
      default: return a;
    endcase
  endfunction

  function automatic logic [2:0] flg(input logic [7:0] a);
    return {a[7], (a == 8'h00), ^a};
  endfunction

  logic [7:0] chip_acc;
  always @(posedge clk) begin
    if (rst)              chip_acc <= 8'h00;
    else if (calc_strobe) chip_acc <= alu(calc_op, chip_acc, calc_data);
  end
  assign calc_result = chip_acc;
  assign calc_flags  = flg(chip_acc);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Commands are applied to the model in acceptance order: responses must come back in that order.
  task automatic model_push(input logic [3:0] op, input logic [7:0] data);
    if (op == 4'hB || op == 4'hC) begin
      exp_q.push_back({op, 8'h00, 3'b000, 1'b1});
    end else begin
      if (!(op >= 4'h5 && op <= 4'hA)) m_data = data;
      m_acc = alu(op, m_acc, m_data);
      exp_q.push_back({op, m_acc, flg(m_acc), 1'b0});
      pin_q.push_back({op, m_data});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pin_q.delete();
    strobe_cycs.delete();
    rsp_rise.delete();
    m_acc = 8'h00;
    m_data = 8'h00;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [7:0] data);
    int n;
    n = 0;
    cmd_op = op;
    cmd_data = data;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("push_timeout", 32'd1, 32'd0);
    else model_push(op, data);
    step();
    push_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, (exp_q.size() != 0 || busy) ? 32'd1 : 32'd0, 32'd0);
    step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] act_rsp;
  logic [15:0] held_rsp;
  bit held_pend   = 1'b0;
  bit prev_valid  = 1'b0;
  bit prev_strobe = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held_pend = 1'b0;
        prev_valid = 1'b0;
        prev_strobe = 1'b0;
      end else begin
        act_rsp = {rsp_op, rsp_result, rsp_flags, rsp_err};
        if (held_pend) begin
          check("rsp_valid_hold", {31'b0, rsp_valid}, 32'd1);
          check("rsp_payload_hold", {16'b0, act_rsp}, {16'b0, held_rsp});
        end
        if (rsp_valid && !prev_valid) rsp_rise.push_back(cyc);
        if (rsp_valid) begin
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL rsp_unexpected: got %h required no response", act_rsp);
            end else begin
              check("rsp", {16'b0, act_rsp}, {16'b0, exp_q.pop_front()});
            end
            held_pend = 1'b0;
          end else begin
            held_rsp = act_rsp;
            held_pend = 1'b1;
          end
        end else begin
          held_pend = 1'b0;
        end
        if (calc_strobe) begin
          check("strobe_width", {31'b0, prev_strobe}, 32'd0);
          strobe_cycs.push_back(cyc);
          if (pin_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL strobe_unexpected: got op=%h data=%h required no strobe", calc_op, calc_data);
          end else begin
            check("pins", {20'b0, calc_op, calc_data}, {20'b0, pin_q.pop_front()});
          end
        end
        prev_valid = rsp_valid;
        prev_strobe = calc_strobe;
      end
    end
  end

  // ---------------- stimulus ----------------
  int n_strobes;
  int gap;

  initial begin
    do_reset();
    @(negedge clk);
    check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_strobe", {31'b0, calc_strobe}, 32'd0);
    check("reset_pins", {20'b0, calc_op, calc_data}, 32'd0);
    check("reset_rsp", {16'b0, rsp_op, rsp_result, rsp_flags, rsp_err}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_state", {29'b0, dbg_state_o}, 32'd0);
    step();

    // 1) single add: pin timing and latency
    push_cmd(4'h0, 8'h01);
    wait_idle("t1_drain");
    check("t1_strobe_count", strobe_cycs.size(), 32'd1);
    check("t1_rsp_count", rsp_rise.size(), 32'd1);
    if (strobe_cycs.size() >= 1 && rsp_rise.size() >= 1) begin
      check("t1_push_to_strobe", strobe_cycs[0] - push_cyc, 1 + SETUP_CYCLES);
      check("t1_strobe_to_rsp", rsp_rise[0] - strobe_cycs[0], 2 + CAPTURE_DELAY);
    end

    // 2) back-to-back add/sub with consumer always ready
    do_reset();
    push_cmd(4'h0, 8'h01);
    push_cmd(4'h1, 8'h0F);
    wait_idle("t2_drain");
    check("t2_strobe_count", strobe_cycs.size(), 32'd2);
    if (strobe_cycs.size() >= 2)
      check("t2_strobe_spacing", strobe_cycs[1] - strobe_cycs[0], SETUP_CYCLES + 3 + CAPTURE_DELAY);

    // 3) fill the FIFO behind a stalled response
    force_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(4'h0 + 4'(i), 8'h10 + 8'(i));
    cmd_op = 4'h0;
    cmd_data = 8'h77;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_full_ready", {31'b0, cmd_ready}, 32'd0);
    end
    step();
    cmd_valid = 1'b0;
    check("t3_busy", {31'b0, busy}, 32'd1);
    force_ready = 1'b1;
    wait_idle("t3_drain");

    // 4) unary op keeps the previous operand on the pins
    push_cmd(4'h4, 8'h55);
    push_cmd(4'h5, 8'hAA);
    wait_idle("t4_drain");
    check("t4_last_data", {24'b0, calc_data}, 32'h55);

    // 5) reserved opcodes never strobe; the next command runs normally
    n_strobes = strobe_cycs.size();
    push_cmd(4'hB, 8'h33);
    push_cmd(4'hC, 8'h44);
    push_cmd(4'h0, 8'h02);
    wait_idle("t5_drain");
    check("t5_strobe_count", strobe_cycs.size() - n_strobes, 32'd1);

    // 6) reset while the strobe is high
    push_cmd(4'h0, 8'h09);
    push_cmd(4'h3, 8'hF0);
    begin
      int n;
      n = 0;
      while (!calc_strobe && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t6_reach_strobe", {31'b0, calc_strobe}, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pin_q.delete();
    m_acc = 8'h00;
    m_data = 8'h00;
    @(negedge clk);
    check("t6_strobe", {31'b0, calc_strobe}, 32'd0);
    check("t6_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t6_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("t6_busy", {31'b0, busy}, 32'd0);
    repeat (10) step();
    push_cmd(4'hD, 8'h3C);
    wait_idle("t6_drain");

    // 7) random commands with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      push_cmd(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
    end
    wait_idle("t7_drain");
    rand_ready = 1'b0;

    check("pins_left", pin_q.size(), 32'd0);
    check("rsp_left", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
